// File: rtl/arm_decode_pkg.sv
// Shared types and constants for the ARM data-processing/multiply decode stage.
package arm_decode_pkg;

   // Micro-op class presented to the execute stage.
   typedef enum logic [3:0] {
      MODE_NONE   = 4'd0,
      MODE_DP_ALU = 4'd1,
      MODE_DP_MOV = 4'd2,
      MODE_MUL    = 4'd3,
      MODE_MLA    = 4'd4,
      MODE_MUL_LO = 4'd5,
      MODE_MUL_HI = 4'd6
   } mode_e;

   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

   // Logic-unit function select (logicidx) when islogic is set.
   localparam logic [2:0] LOGIC_AND = 3'd0, LOGIC_EOR = 3'd1, LOGIC_ORR = 3'd2, LOGIC_PASSB = 3'd3;

   typedef struct packed {
      logic       invert_a;
      logic       invert_b;
      logic       islogic;
      logic       alu_cin;
      logic [2:0] logicidx;
      logic       special;    // carry-in comes from the C flag (ADC/SBC/RSC)
   } alu_ctl_t;

   // ARM condition evaluation on {N,Z,C,V}; the NV slot never passes.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: cond_pass = z;
         COND_NE: cond_pass = !z;
         COND_CS: cond_pass = c;
         COND_CC: cond_pass = !c;
         COND_MI: cond_pass = n;
         COND_PL: cond_pass = !n;
         COND_VS: cond_pass = v;
         COND_VC: cond_pass = !v;
         COND_HI: cond_pass = c && !z;
         COND_LS: cond_pass = !c || z;
         COND_GE: cond_pass = (n == v);
         COND_LT: cond_pass = (n != v);
         COND_GT: cond_pass = !z && (n == v);
         COND_LE: cond_pass = z || (n != v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/arm_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface arm_decode_if #(
   parameter int REG_IDX_W = 4,
   parameter int SHAMT_W   = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic [3:0]           flags_nzcv;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_mode;
   logic [7:0]           out_alu_ctl;
   logic [2+SHAMT_W:0]   out_shift;
   logic [1:0]           out_imm;
   logic [REG_IDX_W-1:0] out_rn, out_rd, out_rm, out_rs;
   logic                 out_reg_w, out_s_on, out_cond_pass, out_illegal;

   // Environment side: supplies instructions and consumes uops.
   modport master (
      output in_valid, in_instr, flags_nzcv, out_ready,
      input  in_ready, out_valid, out_mode, out_alu_ctl, out_shift, out_imm,
             out_rn, out_rd, out_rm, out_rs, out_reg_w, out_s_on, out_cond_pass, out_illegal
   );

   // Decode stage side.
   modport slave (
      input  in_valid, in_instr, flags_nzcv, out_ready,
      output in_ready, out_valid, out_mode, out_alu_ctl, out_shift, out_imm,
             out_rn, out_rd, out_rm, out_rs, out_reg_w, out_s_on, out_cond_pass, out_illegal
   );
endinterface

// File: rtl/arm_decode_comb.sv
// Purely combinational instruction -> uop field decoder.
module arm_decode_comb
   import arm_decode_pkg::*;
#(
   parameter int REG_IDX_W   = 4,
   parameter int SHAMT_W     = 5,
   parameter int LONG_MUL_EN = 1,
   parameter int COND_EN     = 1
) (
   input  logic [31:0]          instr,
   input  logic [3:0]           nzcv,
   input  logic                 hi_sel,     // produce the RdHi half of a long multiply
   output mode_e                mode,
   output alu_ctl_t             alu_ctl,
   output logic [2+SHAMT_W:0]   shift,
   output logic [1:0]           imm,
   output logic [REG_IDX_W-1:0] rn, rd, rm, rs,
   output logic                 reg_w, s_on, cond_ok, illegal,
   output logic                 long_mul    // passing long multiply: a HI uop must follow
);
   logic [3:0] op;
   logic       cp;
   logic       is_mul;

   // Field decode; illegal encodings collapse to an all-zero uop flagged illegal.
   always_comb begin
      mode     = MODE_NONE;
      alu_ctl  = '0;
      shift    = '0;
      imm      = '0;
      rn       = '0;
      rd       = '0;
      rm       = '0;
      rs       = '0;
      reg_w    = 1'b0;
      s_on     = 1'b0;
      illegal  = 1'b0;
      long_mul = 1'b0;
      op       = instr[24:21];
      cp       = (COND_EN != 0) ? cond_pass(instr[31:28], nzcv) : 1'b1;
      cond_ok  = cp;
      is_mul   = (instr[27:24] == 4'b0000) && (instr[7:4] == 4'b1001);

      if ((COND_EN != 0) && (instr[31:28] == COND_NV)) illegal = 1'b1;

      if (instr[27:26] != 2'b00) begin
         illegal = 1'b1;
      end else if (is_mul) begin
         rs    = REG_IDX_W'(instr[11:8]);
         rm    = REG_IDX_W'(instr[3:0]);
         reg_w = 1'b1;
         s_on  = instr[20];
         if (instr[23]) begin
            if (LONG_MUL_EN != 0) begin
               long_mul         = 1'b1;
               alu_ctl.logicidx = {1'b0, instr[22], instr[21]};   // {signed, accumulate}
               if (hi_sel) begin
                  mode = MODE_MUL_HI;
                  rd   = REG_IDX_W'(instr[19:16]);
                  rn   = REG_IDX_W'(instr[19:16]);
               end else begin
                  mode = MODE_MUL_LO;
                  rd   = REG_IDX_W'(instr[15:12]);
                  rn   = REG_IDX_W'(instr[15:12]);
               end
            end else begin
               illegal = 1'b1;
            end
         end else if (instr[22]) begin
            illegal = 1'b1;
         end else begin
            mode = instr[21] ? MODE_MLA : MODE_MUL;
            rd   = REG_IDX_W'(instr[19:16]);
            rn   = REG_IDX_W'(instr[15:12]);
         end
      end else if (!instr[25] && instr[7] && instr[4]) begin
         // Halfword/swap extension space is not handled by this stage.
         illegal = 1'b1;
      end else begin
         mode  = (op == OP_MOV || op == OP_MVN) ? MODE_DP_MOV : MODE_DP_ALU;
         rn    = REG_IDX_W'(instr[19:16]);
         rd    = REG_IDX_W'(instr[15:12]);
         rm    = REG_IDX_W'(instr[3:0]);
         reg_w = 1'b1;
         s_on  = instr[20];
         case (op)
            OP_AND, OP_TST: begin alu_ctl.islogic = 1'b1; alu_ctl.logicidx = LOGIC_AND; end
            OP_EOR, OP_TEQ: begin alu_ctl.islogic = 1'b1; alu_ctl.logicidx = LOGIC_EOR; end
            OP_SUB, OP_CMP: begin alu_ctl.invert_b = 1'b1; alu_ctl.alu_cin = 1'b1; end
            OP_RSB:         begin alu_ctl.invert_a = 1'b1; alu_ctl.alu_cin = 1'b1; end
            OP_ADC:         begin alu_ctl.special = 1'b1; end
            OP_SBC:         begin alu_ctl.invert_b = 1'b1; alu_ctl.special = 1'b1; end
            OP_RSC:         begin alu_ctl.invert_a = 1'b1; alu_ctl.special = 1'b1; end
            OP_ORR:         begin alu_ctl.islogic = 1'b1; alu_ctl.logicidx = LOGIC_ORR; end
            OP_MOV:         begin alu_ctl.islogic = 1'b1; alu_ctl.logicidx = LOGIC_PASSB; end
            OP_BIC:         begin alu_ctl.invert_b = 1'b1; alu_ctl.islogic = 1'b1; alu_ctl.logicidx = LOGIC_AND; end
            OP_MVN:         begin alu_ctl.invert_b = 1'b1; alu_ctl.islogic = 1'b1; alu_ctl.logicidx = LOGIC_PASSB; end
            default:        ;   // ADD/CMN: plain add
         endcase
         // Compares only set flags; without S the slot belongs to other instructions.
         if (op[3:2] == 2'b10) begin
            reg_w = 1'b0;
            if (!instr[20]) illegal = 1'b1;
         end
         if (instr[25]) begin
            shift = {3'b011, SHAMT_W'({instr[11:8], 1'b0})};
            imm   = 2'b10;
         end else if (instr[4]) begin
            shift = {1'b1, instr[6:5], SHAMT_W'(0)};
            rs    = REG_IDX_W'(instr[11:8]);
         end else begin
            shift = {1'b0, instr[6:5], SHAMT_W'(instr[11:7])};
            imm   = 2'b01;
         end
      end

      if (illegal) begin
         mode     = MODE_NONE;
         alu_ctl  = '0;
         shift    = '0;
         imm      = '0;
         rn       = '0;
         rd       = '0;
         rm       = '0;
         rs       = '0;
         reg_w    = 1'b0;
         s_on     = 1'b0;
         long_mul = 1'b0;
      end else if (!cp) begin
         reg_w    = 1'b0;
         s_on     = 1'b0;
         long_mul = 1'b0;
      end
   end
endmodule

// File: rtl/arm_decode_stage.sv
// Registered decode stage: accepts one instruction, issues one uop (two for long multiplies).
module arm_decode_stage
   import arm_decode_pkg::*;
#(
   parameter int REG_IDX_W   = 4,
   parameter int SHAMT_W     = 5,
   parameter int LONG_MUL_EN = 1,
   parameter int COND_EN     = 1
) (
   input logic        clk,
   input logic        rst_n,
   input logic        flush,
   arm_decode_if.slave bus
);
   typedef enum logic {ST_IDLE, ST_HI} state_e;

   typedef struct packed {
      logic [3:0]           mode;
      logic [7:0]           alu;
      logic [2+SHAMT_W:0]   shift;
      logic [1:0]           imm;
      logic [REG_IDX_W-1:0] rn, rd, rm, rs;
      logic                 reg_w, s_on, cond_pass, illegal;
   } uop_t;

   state_e               state;
   logic                 vld_p1;
   uop_t                 uop_p1;
   uop_t                 c_uop;
   logic [31:0]          hold_instr;
   logic [3:0]           hold_nzcv;
   logic                 accept;
   logic                 in_hi;

   mode_e                c_mode;
   alu_ctl_t             c_alu;
   logic [2+SHAMT_W:0]   c_shift;
   logic [1:0]           c_imm;
   logic [REG_IDX_W-1:0] c_rn, c_rd, c_rm, c_rs;
   logic                 c_reg_w, c_s_on, c_cond, c_ill, c_long;

   assign in_hi       = (state == ST_HI);
   assign bus.in_ready = (state == ST_IDLE) && (!vld_p1 || bus.out_ready);
   assign accept      = bus.in_valid && bus.in_ready && !flush;

   // In HI the decoder re-reads the saved instruction and flags to build the RdHi uop.
   arm_decode_comb #(
      .REG_IDX_W  (REG_IDX_W),
      .SHAMT_W    (SHAMT_W),
      .LONG_MUL_EN(LONG_MUL_EN),
      .COND_EN    (COND_EN)
   ) u_comb (
      .instr   (in_hi ? hold_instr : bus.in_instr),
      .nzcv    (in_hi ? hold_nzcv : bus.flags_nzcv),
      .hi_sel  (in_hi),
      .mode    (c_mode),
      .alu_ctl (c_alu),
      .shift   (c_shift),
      .imm     (c_imm),
      .rn      (c_rn),
      .rd      (c_rd),
      .rm      (c_rm),
      .rs      (c_rs),
      .reg_w   (c_reg_w),
      .s_on    (c_s_on),
      .cond_ok (c_cond),
      .illegal (c_ill),
      .long_mul(c_long)
   );

   assign c_uop = {c_mode, c_alu, c_shift, c_imm, c_rn, c_rd, c_rm, c_rs,
                   c_reg_w, c_s_on, c_cond, c_ill};

   // Instruction and flags saved at acceptance for the second long-multiply uop.
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_instr <= bus.in_instr;
         hold_nzcv  <= bus.flags_nzcv;
      end
   end

   // Stage p1: uop register, valid and IDLE/HI sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         vld_p1 <= 1'b0;
         uop_p1 <= '0;
      end else if (flush) begin
         state  <= ST_IDLE;
         vld_p1 <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (accept) begin
            vld_p1 <= 1'b1;
            uop_p1 <= c_uop;
            state  <= c_long ? ST_HI : ST_IDLE;
         end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
         end
      end else if (vld_p1 && bus.out_ready) begin
         if (uop_p1.mode == 4'(MODE_MUL_LO)) begin
            uop_p1 <= c_uop;
         end else begin
            vld_p1 <= 1'b0;
            state  <= ST_IDLE;
         end
      end
   end

   assign bus.out_valid     = vld_p1;
   assign bus.out_mode      = uop_p1.mode;
   assign bus.out_alu_ctl   = uop_p1.alu;
   assign bus.out_shift     = uop_p1.shift;
   assign bus.out_imm       = uop_p1.imm;
   assign bus.out_rn        = uop_p1.rn;
   assign bus.out_rd        = uop_p1.rd;
   assign bus.out_rm        = uop_p1.rm;
   assign bus.out_rs        = uop_p1.rs;
   assign bus.out_reg_w     = uop_p1.reg_w;
   assign bus.out_s_on      = uop_p1.s_on;
   assign bus.out_cond_pass = uop_p1.cond_pass;
   assign bus.out_illegal   = uop_p1.illegal;
endmodule
